// File: rtl/pico_in_port_pkg.sv
// Shared constants for the PicoBlaze port map: port IDs, status/event bit indices and FSM states.
// The port IDs are also used by the write-side decoder.
package pico_in_port_pkg;

  localparam logic [3:0] PortSeg      = 4'h1;
  localparam logic [3:0] PortMin      = 4'h2;
  localparam logic [3:0] PortHora     = 4'h3;
  localparam logic [3:0] PortDia      = 4'h7;
  localparam logic [3:0] PortMes      = 4'h8;
  localparam logic [3:0] PortAno      = 4'h9;
  localparam logic [3:0] PortEvents   = 4'hA;
  localparam logic [3:0] PortSwitches = 4'hB;
  localparam logic [3:0] PortStatus   = 4'hC;

  localparam int unsigned StatFresh   = 0;
  localparam int unsigned StatOverrun = 1;
  localparam int unsigned StatLocked  = 2;
  localparam int unsigned StatTdone   = 3;

  localparam int unsigned EvtUp     = 0;
  localparam int unsigned EvtDown   = 1;
  localparam int unsigned EvtLeft   = 2;
  localparam int unsigned EvtRight  = 3;
  localparam int unsigned EvtEnter  = 4;
  localparam int unsigned NumEvents = 5;

  typedef enum logic {
    SnapUnlocked,
    SnapLocked
  } snap_state_e;

  typedef enum logic [1:0] {
    IntIdle,
    IntReq,
    IntAcked
  } int_state_e;

endpackage

// File: rtl/pico_in_port_sync_bus.sv
// N-bit multi-stage synchronizer for asynchronous level inputs.
module sync_bus #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(STAGES); i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < int'(STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pico_in_port.sv
// PicoBlaze INPUT-side port block: RTC snapshot with lock, read-to-clear events,
// synchronized switches, status byte and interrupt handshake.
module pico_in_port
  import pico_in_port_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] rtc_seg,
  input  logic [7:0] rtc_min,
  input  logic [7:0] rtc_hora,
  input  logic [7:0] rtc_dia,
  input  logic [7:0] rtc_mes,
  input  logic [7:0] rtc_ano,
  input  logic       rtc_valid,
  input  logic [4:0] btn,
  input  logic [3:0] sw,
  input  logic       timer_done
);

  logic [7:0] r_seg, r_min, r_hora, r_dia, r_mes, r_ano;
  logic [NumEvents-1:0] r_events;
  logic r_fresh, r_overrun, r_tdone;
  logic [7:0] r_in_port;
  snap_state_e r_snap_state, w_snap_next;
  int_state_e r_int_state, w_int_next;

  logic [3:0] w_sw_sync;
  logic w_rd_seg, w_rd_ano, w_rd_evt, w_rd_stat;
  logic w_load, w_irq_src;
  logic [7:0] w_status, w_rd_data;

  sync_bus #(
    .WIDTH (4),
    .STAGES(SYNC_STAGES)
  ) u_sw_sync (
    .i_clk  (clk),
    .i_reset(reset),
    .i_d    (sw),
    .o_q    (w_sw_sync)
  );

  assign w_rd_seg  = read_strobe && (port_id == PortSeg);
  assign w_rd_ano  = read_strobe && (port_id == PortAno);
  assign w_rd_evt  = read_strobe && (port_id == PortEvents);
  assign w_rd_stat = read_strobe && (port_id == PortStatus);

  // A seg read coinciding with rtc_valid drops the pulse so the snapshot stays coherent.
  assign w_load    = (r_snap_state == SnapUnlocked) && rtc_valid && !w_rd_seg;
  assign w_irq_src = (|r_events) || r_fresh || r_tdone;

  always_comb begin
    w_status             = 8'h00;
    w_status[StatFresh]   = r_fresh;
    w_status[StatOverrun] = r_overrun;
    w_status[StatLocked]  = (r_snap_state == SnapLocked);
    w_status[StatTdone]   = r_tdone;
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (port_id)
      PortSeg:      w_rd_data = r_seg;
      PortMin:      w_rd_data = r_min;
      PortHora:     w_rd_data = r_hora;
      PortDia:      w_rd_data = r_dia;
      PortMes:      w_rd_data = r_mes;
      PortAno:      w_rd_data = r_ano;
      PortEvents:   w_rd_data = {3'b000, r_events};
      PortSwitches: w_rd_data = {4'h0, w_sw_sync};
      PortStatus:   w_rd_data = w_status;
      default:      w_rd_data = 8'h00;
    endcase
  end

  always_comb begin
    w_snap_next = r_snap_state;
    case (r_snap_state)
      SnapUnlocked: if (w_rd_seg) w_snap_next = SnapLocked;
      SnapLocked:   if (w_rd_ano) w_snap_next = SnapUnlocked;
      default:      w_snap_next = SnapUnlocked;
    endcase
  end

  always_comb begin
    w_int_next = r_int_state;
    case (r_int_state)
      IntIdle:  if (w_irq_src) w_int_next = IntReq;
      IntReq:   if (interrupt_ack) w_int_next = IntAcked;
      IntAcked: if (w_rd_evt || w_rd_stat) w_int_next = IntIdle;
      default:  w_int_next = IntIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap_state <= SnapUnlocked;
      r_int_state  <= IntIdle;
      r_seg        <= 8'h00;
      r_min        <= 8'h00;
      r_hora       <= 8'h00;
      r_dia        <= 8'h00;
      r_mes        <= 8'h00;
      r_ano        <= 8'h00;
      r_events     <= '0;
      r_fresh      <= 1'b0;
      r_overrun    <= 1'b0;
      r_tdone      <= 1'b0;
      r_in_port    <= 8'h00;
    end else begin
      r_snap_state <= w_snap_next;
      r_int_state  <= w_int_next;
      r_in_port    <= w_rd_data;
      if (w_load) begin
        r_seg  <= rtc_seg;
        r_min  <= rtc_min;
        r_hora <= rtc_hora;
        r_dia  <= rtc_dia;
        r_mes  <= rtc_mes;
        r_ano  <= rtc_ano;
      end
      if (w_rd_seg)    r_fresh <= 1'b0;
      else if (w_load) r_fresh <= 1'b1;
      // New pulses win over a coincident read-to-clear.
      r_events  <= (w_rd_evt ? '0 : r_events) | btn;
      r_tdone   <= (r_tdone & ~w_rd_stat) | timer_done;
      r_overrun <= (r_overrun & ~w_rd_stat) | (rtc_valid & ~w_load);
    end
  end

  assign in_port   = r_in_port;
  assign interrupt = (r_int_state == IntReq);

endmodule

// File: tb/tb_pico_in_port.sv
// Randomized and directed bench for pico_in_port against a cycle-level behavioural model.
module tb_pico_in_port;

  localparam int unsigned SyncStages = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] port_id;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] rtc_seg, rtc_min, rtc_hora, rtc_dia, rtc_mes, rtc_ano;
  logic       rtc_valid;
  logic [4:0] btn;
  logic [3:0] sw;
  logic       timer_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pico_in_port #(
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .rtc_seg      (rtc_seg),
    .rtc_min      (rtc_min),
    .rtc_hora     (rtc_hora),
    .rtc_dia      (rtc_dia),
    .rtc_mes      (rtc_mes),
    .rtc_ano      (rtc_ano),
    .rtc_valid    (rtc_valid),
    .btn          (btn),
    .sw           (sw),
    .timer_done   (timer_done)
  );

  // Reference model: shadow index 0..5 = seg, min, hora, dia, mes, ano.
  logic [7:0] m_shadow [6];
  bit         m_locked, m_fresh, m_over, m_tdone;
  logic [4:0] m_evt;
  int         m_int;  // 0 idle, 1 requesting, 2 acknowledged
  logic [3:0] m_sw_q [$];
  logic [7:0] m_in_port;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_shadow[i] = 8'h00;
    m_locked = 0; m_fresh = 0; m_over = 0; m_tdone = 0;
    m_evt = '0; m_int = 0; m_in_port = 8'h00;
    m_sw_q = {};
    for (int i = 0; i < int'(SyncStages); i++) m_sw_q.push_back(4'h0);
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] id);
    case (id)
      4'h1: return m_shadow[0];
      4'h2: return m_shadow[1];
      4'h3: return m_shadow[2];
      4'h7: return m_shadow[3];
      4'h8: return m_shadow[4];
      4'h9: return m_shadow[5];
      4'hA: return {3'b000, m_evt};
      4'hB: return {4'h0, m_sw_q[0]};
      4'hC: return {4'h0, m_tdone, m_locked, m_over, m_fresh};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_edge();
    bit rs_seg, rs_ano, rs_evt, rs_stat, any_src, loaded;
    logic [7:0] rd;
    if (reset) begin
      m_reset();
      return;
    end
    rd      = m_read(port_id);
    rs_seg  = read_strobe && port_id == 4'h1;
    rs_ano  = read_strobe && port_id == 4'h9;
    rs_evt  = read_strobe && port_id == 4'hA;
    rs_stat = read_strobe && port_id == 4'hC;
    any_src = (m_evt != 0) || m_fresh || m_tdone;
    case (m_int)
      0: if (any_src) m_int = 1;
      1: if (interrupt_ack) m_int = 2;
      default: if (rs_evt || rs_stat) m_int = 0;
    endcase
    loaded = rtc_valid && !m_locked && !rs_seg;
    m_over = (m_over && !rs_stat) || (rtc_valid && !loaded);
    if (loaded) begin
      m_shadow[0] = rtc_seg;  m_shadow[1] = rtc_min; m_shadow[2] = rtc_hora;
      m_shadow[3] = rtc_dia;  m_shadow[4] = rtc_mes; m_shadow[5] = rtc_ano;
    end
    if (rs_seg) m_fresh = 0;
    else if (loaded) m_fresh = 1;
    if (!m_locked && rs_seg) m_locked = 1;
    else if (m_locked && rs_ano) m_locked = 0;
    m_evt   = (rs_evt ? 5'h00 : m_evt) | btn;
    m_tdone = (m_tdone && !rs_stat) || timer_done;
    void'(m_sw_q.pop_front());
    m_sw_q.push_back(sw);
    m_in_port = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    chk("in_port", in_port, m_in_port);
    chk("interrupt", {7'h0, interrupt}, {7'h0, (m_int == 1)});
  endtask

  task automatic rd(input logic [3:0] id, input logic [7:0] exp, input string tag);
    port_id = id;
    read_strobe = 1'b0;
    tick();
    chk(tag, in_port, exp);
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic rtc_pulse(input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h,
                           input logic [7:0] d, input logic [7:0] me, input logic [7:0] a);
    rtc_seg = s; rtc_min = mi; rtc_hora = h; rtc_dia = d; rtc_mes = me; rtc_ano = a;
    rtc_valid = 1'b1;
    tick();
    rtc_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; port_id = 4'h0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    rtc_seg = 8'h00; rtc_min = 8'h00; rtc_hora = 8'h00; rtc_dia = 8'h00;
    rtc_mes = 8'h00; rtc_ano = 8'h00; rtc_valid = 1'b0; btn = 5'h00; sw = 4'h0;
    timer_done = 1'b0;
    m_reset();
    tick();
    tick();
    chk("reset_in_port", in_port, 8'h00);
    chk("reset_irq", {7'h0, interrupt}, 8'h00);
    reset = 1'b0;
    tick();

    // Snapshot load and coherent reads.
    rtc_pulse(8'h45, 8'h30, 8'h12, 8'h24, 8'h10, 8'h16);
    rd(4'hC, 8'h01, "status_fresh");
    rd(4'h1, 8'h45, "seg");
    rd(4'hC, 8'h04, "status_locked");
    rd(4'h2, 8'h30, "min");
    rd(4'h3, 8'h12, "hora");
    rd(4'h7, 8'h24, "dia");
    rd(4'h8, 8'h10, "mes");

    // Update while locked is held off and flagged as overrun.
    rtc_pulse(8'h46, 8'h30, 8'h12, 8'h24, 8'h10, 8'h16);
    rd(4'h1, 8'h45, "seg_held");
    rd(4'hC, 8'h06, "status_overrun");
    rd(4'h9, 8'h16, "ano_unlock");
    rtc_pulse(8'h46, 8'h30, 8'h12, 8'h24, 8'h10, 8'h16);
    rd(4'h1, 8'h46, "seg_reload");
    rd(4'h9, 8'h16, "ano_unlock2");

    // Drain the pending request left by the fresh flag.
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    rd(4'hA, 8'h00, "evt_empty");

    // Button event interrupt handshake.
    btn = 5'b00100; tick(); btn = 5'h00;
    chk("irq_not_yet", {7'h0, interrupt}, 8'h00);
    tick();
    chk("irq_rise", {7'h0, interrupt}, 8'h01);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    chk("irq_fall", {7'h0, interrupt}, 8'h00);
    rd(4'hA, 8'h04, "evt_btn2");
    rd(4'hA, 8'h00, "evt_cleared");

    // Timer-done flag proves the interrupt FSM returned to idle.
    timer_done = 1'b1; tick(); timer_done = 1'b0;
    tick();
    chk("tdone_irq", {7'h0, interrupt}, 8'h01);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    rd(4'hC, 8'h08, "status_tdone");
    rd(4'hC, 8'h00, "status_clear");

    // Set wins over a coincident read-to-clear.
    btn = 5'b00010; tick(); btn = 5'h00;
    port_id = 4'hA; tick();
    chk("evt_old", in_port, 8'h02);
    read_strobe = 1'b1; btn = 5'b00001; tick();
    read_strobe = 1'b0; btn = 5'h00;
    rd(4'hA, 8'h01, "evt_set_wins");
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    rd(4'hA, 8'h00, "evt_clear");

    // Switch synchronizer latency and unmapped IDs.
    sw = 4'hA; port_id = 4'hB;
    tick(); tick();
    chk("sw_latency", in_port, 8'h00);
    tick();
    chk("sw_sync", in_port, 8'h0A);
    rd(4'h0, 8'h00, "unmapped_0");
    rd(4'hF, 8'h00, "unmapped_f");

    // Asynchronous reset while locked with events pending.
    rd(4'h1, 8'h46, "lock_again");
    btn = 5'h1F; tick(); btn = 5'h00;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_in_port", in_port, 8'h00);
    chk("rst_irq", {7'h0, interrupt}, 8'h00);
    m_reset();
    tick();
    reset = 1'b0;
    rd(4'hC, 8'h00, "rst_status");
    rd(4'hA, 8'h00, "rst_events");
    rtc_pulse(8'h59, 8'h58, 8'h23, 8'h31, 8'h12, 8'h99);
    rd(4'h1, 8'h59, "reload_seg");
    rd(4'h9, 8'h99, "reload_ano");

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 2 == 0) port_id = 4'($urandom_range(0, 15));
      read_strobe   = ($urandom_range(0, 3) == 0);
      interrupt_ack = ($urandom_range(0, 5) == 0);
      timer_done    = ($urandom_range(0, 19) == 0);
      for (int b = 0; b < 5; b++) btn[b] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) sw = 4'($urandom_range(0, 15));
      rtc_valid = ($urandom_range(0, 7) == 0);
      rtc_seg  = 8'($urandom); rtc_min = 8'($urandom); rtc_hora = 8'($urandom);
      rtc_dia  = 8'($urandom); rtc_mes = 8'($urandom); rtc_ano  = 8'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0; timer_done = 1'b0;
    btn = 5'h00; rtc_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
